// File: rtl/psk_mapper_if.sv
// Symbol-in / sample-out handshake bundle for the M-PSK symbol mapper.
interface psk_mapper_if;
    logic [5:0]         n_points;
    logic [5:0]         sym_index;
    logic               sym_valid;
    logic               sym_ready;
    logic signed [15:0] out_i;
    logic signed [15:0] out_q;
    logic               out_err;
    logic               out_valid;
    logic               out_ready;

    modport master (output n_points, sym_index, sym_valid, out_ready,
                    input  sym_ready, out_i, out_q, out_err, out_valid);
    modport slave  (input  n_points, sym_index, sym_valid, out_ready,
                    output sym_ready, out_i, out_q, out_err, out_valid);
endinterface

// File: rtl/psk_mapper.sv
// M-PSK symbol mapper: index -> sector-centre phase -> iterative CORDIC -> Q8.8 I/Q.
// Phase units are 1/256 rad (2*pi = 1608); illegal symbols yield (0,0) with out_err.
module psk_mapper #(
    parameter int unsigned        ITERATIONS = 9,
    parameter logic signed [15:0] K_INIT     = 16'sd155
) (
    input  logic        clk,
    input  logic        rst_n,
    psk_mapper_if.slave io_bus
);
    localparam int unsigned XW = 18;
    localparam int unsigned ZW = 16;
    localparam int unsigned OW = 16;
    localparam int unsigned PW = 16;
    localparam int unsigned CW = 4;

    localparam logic [PW-1:0]        TWO_PI  = PW'(1608);
    localparam logic [PW-1:0]        HALF_PI = PW'(402);
    localparam logic [PW-1:0]        PI      = PW'(804);
    localparam logic [PW-1:0]        PI_1_5  = PW'(1206);
    localparam logic [PW-1:0]        OFFSET  = PW'(201);
    localparam logic signed [XW-1:0] SAT_MAX = XW'(32767);
    localparam logic signed [XW-1:0] SAT_MIN = -XW'(32768);

    typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_t;

    state_t               r_state, w_state_next;
    logic signed [XW-1:0] r_x, r_y, w_x_next, w_y_next;
    logic signed [ZW-1:0] r_z, w_z_next;
    logic [CW-1:0]        r_iter, w_iter_next;
    logic                 r_err, w_err_next;
    logic signed [OW-1:0] r_out_i, r_out_q, w_out_i_next, w_out_q_next;
    logic                 r_out_err, w_out_err_next;
    logic                 r_out_valid, w_out_valid_next;

    logic [PW-1:0]        w_step, w_phase_raw, w_phase;
    logic                 w_n_legal, w_legal;
    logic signed [XW-1:0] w_x0, w_x_sh, w_y_sh, w_x_rot, w_y_rot;
    logic signed [ZW-1:0] w_z0, w_z_rot, w_atan;
    logic                 w_dpos;

    function automatic logic signed [ZW-1:0] atan_lut(input logic [CW-1:0] idx);
        case (idx)
            4'd0:    return ZW'(201);
            4'd1:    return ZW'(119);
            4'd2:    return ZW'(63);
            4'd3:    return ZW'(32);
            4'd4:    return ZW'(16);
            4'd5:    return ZW'(8);
            4'd6:    return ZW'(4);
            4'd7:    return ZW'(2);
            4'd8:    return ZW'(1);
            default: return '0;
        endcase
    endfunction

    function automatic logic signed [OW-1:0] sat_out(input logic signed [XW-1:0] v);
        if (v > SAT_MAX)      return OW'(SAT_MAX);
        else if (v < SAT_MIN) return OW'(SAT_MIN);
        else                  return OW'(v);
    endfunction

    // Angular step between adjacent constellation points
    always_comb begin
        w_step    = '0;
        w_n_legal = 1'b1;
        case (io_bus.n_points)
            6'd4:    w_step = PW'(402);
            6'd8:    w_step = PW'(201);
            6'd12:   w_step = PW'(134);
            6'd16:   w_step = PW'(100);
            default: w_n_legal = 1'b0;
        endcase
    end

    assign w_legal     = w_n_legal && (io_bus.sym_index < io_bus.n_points);
    assign w_phase_raw = OFFSET + PW'(io_bus.sym_index) * w_step;
    assign w_phase     = (w_phase_raw >= TWO_PI) ? w_phase_raw - TWO_PI : w_phase_raw;

    // Fold the phase into [-pi/2, pi/2) so the CORDIC converges
    always_comb begin
        w_x0 = XW'(K_INIT);
        w_z0 = signed'(w_phase);
        if (!w_legal) begin
            w_x0 = '0;
            w_z0 = '0;
        end else if (w_phase < HALF_PI) begin
            w_z0 = signed'(w_phase);
        end else if (w_phase < PI_1_5) begin
            w_x0 = -XW'(K_INIT);
            w_z0 = signed'(w_phase - PI);
        end else begin
            w_z0 = signed'(w_phase - TWO_PI);
        end
    end

    assign w_dpos  = ~r_z[ZW-1];
    assign w_x_sh  = r_x >>> r_iter;
    assign w_y_sh  = r_y >>> r_iter;
    assign w_atan  = atan_lut(r_iter);
    assign w_x_rot = w_dpos ? (r_x - w_y_sh) : (r_x + w_y_sh);
    assign w_y_rot = w_dpos ? (r_y + w_x_sh) : (r_y - w_x_sh);
    assign w_z_rot = w_dpos ? (r_z - w_atan) : (r_z + w_atan);

    always_comb begin
        w_state_next     = r_state;
        w_x_next         = r_x;
        w_y_next         = r_y;
        w_z_next         = r_z;
        w_iter_next      = r_iter;
        w_err_next       = r_err;
        w_out_i_next     = r_out_i;
        w_out_q_next     = r_out_q;
        w_out_err_next   = r_out_err;
        w_out_valid_next = r_out_valid;
        case (r_state)
            IDLE: begin
                if (io_bus.sym_valid) begin
                    w_x_next     = w_x0;
                    w_y_next     = '0;
                    w_z_next     = w_z0;
                    w_iter_next  = '0;
                    w_err_next   = ~w_legal;
                    w_state_next = ROTATE;
                end
            end
            ROTATE: begin
                w_x_next    = w_x_rot;
                w_y_next    = w_y_rot;
                w_z_next    = w_z_rot;
                w_iter_next = r_iter + 1'b1;
                if (r_iter == CW'(ITERATIONS - 1)) begin
                    w_out_i_next     = r_err ? '0 : sat_out(w_x_rot);
                    w_out_q_next     = r_err ? '0 : sat_out(w_y_rot);
                    w_out_err_next   = r_err;
                    w_out_valid_next = 1'b1;
                    w_state_next     = DONE;
                end
            end
            DONE: begin
                if (io_bus.out_ready) begin
                    w_out_valid_next = 1'b0;
                    w_state_next     = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_z         <= '0;
            r_iter      <= '0;
            r_err       <= 1'b0;
            r_out_i     <= '0;
            r_out_q     <= '0;
            r_out_err   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_x         <= w_x_next;
            r_y         <= w_y_next;
            r_z         <= w_z_next;
            r_iter      <= w_iter_next;
            r_err       <= w_err_next;
            r_out_i     <= w_out_i_next;
            r_out_q     <= w_out_q_next;
            r_out_err   <= w_out_err_next;
            r_out_valid <= w_out_valid_next;
        end
    end

    assign io_bus.sym_ready = (r_state == IDLE);
    assign io_bus.out_i     = r_out_i;
    assign io_bus.out_q     = r_out_q;
    assign io_bus.out_err   = r_out_err;
    assign io_bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_psk_mapper.sv
// Directed self-checking bench for psk_mapper: reset, QPSK points, wrap, illegal
// symbols, backpressure and nearest-centre demapper loopback for all sizes.
module tb_psk_mapper;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    psk_mapper_if bus();

    psk_mapper #(.ITERATIONS(9), .K_INIT(16'sd155)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int hs_cnt = 0;
    int acc_q[$];

    // Edge log: acceptances (cycle stamp) and output handshakes
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && bus.sym_valid && bus.sym_ready) acc_q.push_back(cyc);
        if (rst_n && bus.out_valid && bus.out_ready) hs_cnt <= hs_cnt + 1;
    end

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    task automatic wait_valid(output int lat, output bit to);
        to  = 1'b1;
        lat = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                to = 1'b0;
                break;
            end
        end
        if (!to && acc_q.size() > 0) lat = cyc - acc_q[acc_q.size()-1] - 1;
    endtask

    task automatic run_one(input int n, input int idx, output int vi, output int vq,
                           output logic verr, output int lat, output bit to);
        @(negedge clk);
        bus.n_points  = 6'(n);
        bus.sym_index = 6'(idx);
        bus.sym_valid = 1'b1;
        wait_valid(lat, to);
        bus.sym_valid = 1'b0;
        vi   = int'(bus.out_i);
        vq   = int'(bus.out_q);
        verr = bus.out_err;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int  lat, vi, vq;
        bit  to;
        bit  seen;
        logic verr;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.out_i !== 16'sd0 || bus.out_q !== 16'sd0 || bus.out_err !== 1'b0 ||
            bus.out_valid !== 1'b0 || bus.sym_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_por: i=%0d q=%0d err=%b valid=%b ready=%b, required 0 0 0 0 1",
                     bus.out_i, bus.out_q, bus.out_err, bus.out_valid, bus.sym_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.n_points  = 6'd4;
        bus.sym_index = 6'd1;
        bus.sym_valid = 1'b1;
        @(negedge clk);
        bus.sym_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.sym_ready !== 1'b0) begin
            errors++;
            $display("FAIL rotate_busy: sym_ready=%b, required 0", bus.sym_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_i !== 16'sd0 || bus.out_q !== 16'sd0 || bus.out_err !== 1'b0 ||
            bus.out_valid !== 1'b0 || bus.sym_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_rotate: i=%0d q=%0d err=%b valid=%b ready=%b, required 0 0 0 0 1",
                     bus.out_i, bus.out_q, bus.out_err, bus.out_valid, bus.sym_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_no_pulse: out_valid seen=1, required 0");
        end
        // Same again with the sample parked in DONE
        bus.out_ready = 1'b0;
        run_one(4, 1, vi, vq, verr, lat, to);
        checks++;
        if (to || absd(vi, -181) > 3 || absd(vq, 181) > 3 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL done_hold: to=%b (%0d,%0d) valid=%b, required (-181,181)+-3 valid=1",
                     to, vi, vq, bus.out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_i !== 16'sd0 || bus.out_q !== 16'sd0 || bus.out_valid !== 1'b0 ||
            bus.sym_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_done: i=%0d q=%0d valid=%b ready=%b, required 0 0 0 1",
                     bus.out_i, bus.out_q, bus.out_valid, bus.sym_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_qpsk();
        int exp_i[4] = '{181, -181, -181, 181};
        int exp_q[4] = '{181, 181, -181, -181};
        int base, lat, vi, vq;
        bit to;
        bus.out_ready = 1'b1;
        bus.n_points  = 6'd4;
        @(negedge clk);
        base = acc_q.size();
        bus.sym_index = 6'd0;
        bus.sym_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_valid(lat, to);
            vi = int'(bus.out_i);
            vq = int'(bus.out_q);
            checks++;
            if (to || absd(vi, exp_i[k]) > 3 || absd(vq, exp_q[k]) > 3 || bus.out_err !== 1'b0) begin
                errors++;
                $display("FAIL qpsk_value[%0d]: to=%b (%0d,%0d) err=%b, required (%0d,%0d)+-3 err=0",
                         k, to, vi, vq, bus.out_err, exp_i[k], exp_q[k]);
            end
            checks++;
            if (lat != 9) begin
                errors++;
                $display("FAIL qpsk_latency[%0d]: %0d edges, required 9", k, lat);
            end
            if (k < 3) bus.sym_index = 6'(k + 1);
            else       bus.sym_valid = 1'b0;
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (acc_q.size() < base + 4 || acc_q[base+k+1] - acc_q[base+k] != 11) begin
                errors++;
                $display("FAIL qpsk_spacing[%0d]: accepts=%0d, required 4 spaced 11 cycles",
                         k, acc_q.size() - base);
            end
        end
    endtask

    task automatic test_phase();
        int lat, vi, vq;
        bit to;
        logic verr;
        bus.out_ready = 1'b1;
        run_one(8, 2, vi, vq, verr, lat, to);
        checks++;
        if (to || absd(vi, -181) > 3 || absd(vq, 181) > 3 || verr !== 1'b0) begin
            errors++;
            $display("FAIL psk8_idx2: to=%b (%0d,%0d) err=%b, required (-181,181)+-3 err=0",
                     to, vi, vq, verr);
        end
        run_one(16, 15, vi, vq, verr, lat, to);
        checks++;
        if (to || absd(vi, 239) > 3 || absd(vq, 91) > 3 || verr !== 1'b0) begin
            errors++;
            $display("FAIL psk16_wrap: to=%b (%0d,%0d) err=%b, required (239,91)+-3 err=0",
                     to, vi, vq, verr);
        end
    endtask

    task automatic test_illegal();
        int ns[2]   = '{12, 7};
        int idxs[2] = '{12, 0};
        int lat, vi, vq;
        bit to;
        logic verr;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            run_one(ns[k], idxs[k], vi, vq, verr, lat, to);
            checks++;
            if (to || vi != 0 || vq != 0 || verr !== 1'b1 || lat != 9) begin
                errors++;
                $display("FAIL illegal[%0d]: to=%b (%0d,%0d) err=%b lat=%0d, required (0,0) err=1 lat=9",
                         k, to, vi, vq, verr, lat);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat, n_acc, hs0;
        bit to, stable;
        logic signed [15:0] hold_i, hold_q;
        bus.out_ready = 1'b0;
        bus.n_points  = 6'd4;
        @(negedge clk);
        bus.sym_index = 6'd0;
        bus.sym_valid = 1'b1;
        wait_valid(lat, to);
        hold_i = bus.out_i;
        hold_q = bus.out_q;
        n_acc  = acc_q.size();
        hs0    = hs_cnt;
        stable = !to;
        for (int c = 0; c < 20; c++) begin
            bus.sym_index = 6'(c & 3);
            @(negedge clk);
            if (bus.out_i !== hold_i || bus.out_q !== hold_q || bus.out_valid !== 1'b1 ||
                bus.sym_ready !== 1'b0) stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL bp_stable: (%0d,%0d) valid=%b ready=%b, required (%0d,%0d) valid=1 ready=0",
                     bus.out_i, bus.out_q, bus.out_valid, bus.sym_ready, hold_i, hold_q);
        end
        checks++;
        if (acc_q.size() != n_acc) begin
            errors++;
            $display("FAIL bp_no_accept: %0d accepts, required 0", acc_q.size() - n_acc);
        end
        bus.sym_index = 6'd1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks++;
        if (hs_cnt != hs0 + 1 || bus.out_valid !== 1'b0 || bus.sym_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_handshake: hs=%0d valid=%b ready=%b, required 1 0 1",
                     hs_cnt - hs0, bus.out_valid, bus.sym_ready);
        end
        @(negedge clk);
        bus.sym_valid = 1'b0;
        checks++;
        if (acc_q.size() != n_acc + 1) begin
            errors++;
            $display("FAIL bp_next_accept: %0d accepts, required 1", acc_q.size() - n_acc);
        end
        wait_valid(lat, to);
        checks++;
        if (to || absd(int'(bus.out_i), -181) > 3 || absd(int'(bus.out_q), 181) > 3 ||
            hs_cnt != hs0 + 1) begin
            errors++;
            $display("FAIL bp_next_value: to=%b (%0d,%0d) hs=%0d, required (-181,181)+-3 hs=1",
                     to, bus.out_i, bus.out_q, hs_cnt - hs0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_loopback();
        int sizes[4] = '{4, 8, 12, 16};
        int lat, vi, vq, step, best;
        bit to;
        logic verr;
        real th, dot, best_dot;
        bus.out_ready = 1'b1;
        for (int s = 0; s < 4; s++) begin
            step = 1608 / sizes[s];
            for (int idx = 0; idx < sizes[s]; idx++) begin
                run_one(sizes[s], idx, vi, vq, verr, lat, to);
                best     = -1;
                best_dot = -1.0e9;
                for (int k = 0; k < sizes[s]; k++) begin
                    th  = (201.0 + real'(k * step)) / 256.0;
                    dot = real'(vi) * $cos(th) + real'(vq) * $sin(th);
                    if (dot > best_dot) begin
                        best_dot = dot;
                        best     = k;
                    end
                end
                checks++;
                if (to || verr !== 1'b0 || best != idx) begin
                    errors++;
                    $display("FAIL loopback N=%0d: to=%b err=%b (%0d,%0d) demapped %0d, required %0d",
                             sizes[s], to, verr, vi, vq, best, idx);
                end
            end
        end
    endtask

    initial begin
        bus.n_points  = 6'd4;
        bus.sym_index = 6'd0;
        bus.sym_valid = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_qpsk();
        test_phase();
        test_illegal();
        test_backpressure();
        test_loopback();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/psk_mapper.md
# psk_mapper

Transmit-side M-PSK symbol mapper. It converts a stream of symbol indices into Q8.8 I/Q samples for 4-, 8-, 12- and 16-point constellations. Each index is placed at the centre of the decision sector the PSK demapper assigns to it, so the mapper-to-demapper loopback is identity. Phase generation uses an iterative CORDIC in rotation mode with angle units of 1/256 rad (PI = 804), and the block sits between the symbol source and the DAC/pulse-shaping path.

## Interface
- `ITERATIONS`, default 9, number of CORDIC micro-rotations (legal 1..9).
- `K_INIT`, default 16'sd155, initial x magnitude: round(256 × 0.60725), unit amplitude pre-compensated for CORDIC gain.
- `clk`  input  1  single clock, rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `n_points`  input  6  constellation size (4, 8, 12, 16); sampled at acceptance.
- `sym_index`  input  6  symbol index.
- `sym_valid`  input  1  index valid.
- `sym_ready`  output  1  mapper can accept; equals (state == IDLE).
- `out_i`, `out_q`  output  16 each  signed Q8.8 sample, registered.
- `out_err`  output  1  sample corresponds to an illegal index or `n_points`.
- `out_valid`  output  1  sample valid.
- `out_ready`  input  1  downstream accepts the sample.

## Operation
- Step per `n_points`: 4→402, 8→201, 12→134, 16→100.
- Phase = 201 + `sym_index` × step. If the result is ≥ 1608, subtract 1608 once. This is always sufficient: the maximum is 1701.
- Quadrant pre-rotation (x0, y0, z0):
  - phase < 402: (K_INIT, 0, phase).
  - 402 ≤ phase < 1206: (−K_INIT, 0, phase − 804).
  - phase ≥ 1206: (K_INIT, 0, phase − 1608).
- The atan table, 1/256 rad per LSB, for i = 0..8: 201, 119, 63, 32, 16, 8, 4, 2, 1.
- Iteration i: d = (z ≥ 0) ? +1 : −1.
  - x' = x − d·(y >>> i)
  - y' = y + d·(x >>> i)
  - z' = z − d·atan[i]
  - Shifts are arithmetic.
- Widths: x and y are 18-bit signed; z is 16-bit signed. The final x and y saturate to 16-bit signed into `out_i` and `out_q`.
- Illegal input: `n_points` ∉ {4, 8, 12, 16}, or `sym_index` ≥ `n_points`.
  - Latency and handshake are unchanged.
  - `out_i` = `out_q` = 0 and `out_err` = 1.
- FSM states: IDLE, ROTATE, DONE.
  - IDLE: on `sym_valid`, accept the index, load x, y, z, clear the iteration counter, and go to ROTATE.
  - ROTATE: perform one iteration per cycle. After iteration ITERATIONS−1, register the outputs, set `out_valid`, and go to DONE.
  - DONE: hold `out_i`, `out_q`, `out_err` and `out_valid` stable until `out_ready`. On `out_ready`, clear `out_valid` and go to IDLE.
- Indices are never accepted outside IDLE. `sym_index` and `n_points` changes during ROTATE or DONE have no effect.

## Timing
- Reset, and the async assertion of `rst_n` at any time including mid-ROTATE or DONE:
  - state = IDLE; `out_i` = `out_q` = 0; `out_err` = 0; `out_valid` = 0.
  - Internal x, y, z and the iteration counter are cleared.
  - `sym_ready` = 1.
  - An in-flight symbol is discarded and produces no output.
- Acceptance at edge t (`sym_valid` & `sym_ready`): `out_valid` is high after edge t+ITERATIONS, which is t+9 by default.
- Output handshake at the first edge with `out_valid` & `out_ready`. `sym_ready` is high after that edge; the next acceptance occurs one edge later at the earliest.
- Throughput: with `out_ready` held high and `sym_valid` continuous, one symbol per ITERATIONS+2 cycles (11 by default).
- `out_valid` never drops without a handshake. The output values do not change while `out_valid` = 1.

## Test plan
- Reset during ROTATE after an accepted index (async `rst_n` low between edges):
  - All outputs 0 immediately and `sym_ready` = 1.
  - No `out_valid` pulse after release.
- `n_points` = 4, indices 0, 1, 2, 3, `out_ready` = 1: (181, 181), (−181, 181), (−181, −181), (181, −181), each ±3 LSB, `out_err` = 0.
  - `out_valid` rises 9 edges after each acceptance.
  - Acceptances are spaced 11 cycles apart.
- `n_points` = 8, index 2 (phase 603): (−181, 181) ±3. `n_points` = 16, index 15 (phase wraps to 93): (239, 91) ±3.
- `n_points` = 12, index 12, then `n_points` = 7, index 0: both give (0, 0) with `out_err` = 1, same latency as legal symbols.
- Backpressure: `out_ready` low for 20 cycles after `out_valid`, with `sym_valid` high and the index changing:
  - Output stays stable and `sym_ready` stays 0.
  - After `out_ready` goes high, exactly one handshake occurs, then the next index is accepted.
- Loopback into the PSK demapper for all N ∈ {4, 8, 12, 16} and all legal indices: the recovered index equals the transmitted index.
